// File: rtl/nfu_accum.sv
// Neuron accumulation stage: takes a bias plus a run of signed products from the
// multiplier, sums them in a wide accumulator and returns a saturated N-bit result.
module nfu_accum #(
  parameter int N     = 16,
  parameter int ACC_W = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic [N-1:0]     bias,
  input  logic             prod_valid,
  input  logic [N-1:0]     prod_in,
  output logic             prod_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_data,
  output logic             out_sat,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N-1:0]       outData_q, outData_d;
  logic               outSat_q, outSat_d;

  logic               startAccepted;
  logic               prodFire;
  logic [ACC_W-1:0]   accSum;
  logic [N:0]         satSum;

  // Returns {clipped, value}; the sum fits when every bit from N-1 upward matches the sign.
  function automatic logic [N:0] satResult(input logic [ACC_W-1:0] sum);
    logic [ACC_W-N:0] upper;
    upper = sum[ACC_W-1:N-1];
    if ((&upper) || !(|upper)) begin
      return {1'b0, sum[N-1:0]};
    end else if (sum[ACC_W-1]) begin
      return {1'b1, 1'b1, {(N-1){1'b0}}};
    end else begin
      return {1'b1, 1'b0, {(N-1){1'b1}}};
    end
  endfunction

  assign prod_ready = (state_q == ACCUM);
  assign out_valid  = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign out_data   = outData_q;
  assign out_sat    = outSat_q;

  // A new operation may start from IDLE, or from DONE in the cycle the result is taken.
  assign startAccepted = start && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
  assign prodFire      = prod_valid && prod_ready;
  assign accSum        = acc_q + {{(ACC_W-N){prod_in[N-1]}}, prod_in};
  assign satSum        = satResult(accSum);

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    outData_d = outData_q;
    outSat_d  = outSat_q;

    case (state_q)
      ACCUM: begin
        if (prodFire) begin
          acc_d = accSum;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d   = DONE;
            outData_d = satSum[N-1:0];
            outSat_d  = satSum[N];
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A bias is already N bits wide, so a zero-length operation can never clip.
    if (startAccepted) begin
      acc_d = {{(ACC_W-N){bias[N-1]}}, bias};
      cnt_d = len;
      if (len != '0) begin
        state_d = ACCUM;
      end else begin
        state_d   = DONE;
        outData_d = bias;
        outSat_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      outData_q <= '0;
      outSat_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      outData_q <= outData_d;
      outSat_q  <= outSat_d;
    end
  end

endmodule

// File: tb/tb_nfu_accum.sv
// Scoreboard bench for nfu_accum: stimulus pushes hand-computed results, a
// negedge monitor compares them when the DUT presents a result.
module tb_nfu_accum;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  len;
  logic [15:0] bias;
  logic        prod_valid;
  logic [15:0] prod_in;
  logic        prod_ready;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_sat;
  logic        busy;

  int tests    = 0;
  int failures = 0;

  logic [16:0] expQ[$];

  nfu_accum #(.N(16), .ACC_W(32), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .len        (len),
    .bias       (bias),
    .prod_valid (prod_valid),
    .prod_in    (prod_in),
    .prod_ready (prod_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sat    (out_sat),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: a taken result is popped and compared; a stalled result must match the head entry.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_result", {15'd0, out_sat, out_data}, 32'h1_DEAD);
      end else if (out_ready) begin
        checkOutput("result", {15'd0, out_sat, out_data}, {15'd0, expQ.pop_front()});
      end else begin
        checkOutput("stalled_result", {15'd0, out_sat, out_data}, {15'd0, expQ[0]});
      end
    end
  end

  task automatic applyStimulus(input logic [15:0] b, input logic [7:0] n);
    start = 1'b1;
    bias  = b;
    len   = n;
    tick();
    start = 1'b0;
  endtask

  task automatic sendProd(input logic [15:0] p);
    int waitCycles;
    waitCycles = 0;
    prod_valid = 1'b1;
    prod_in    = p;
    while (!prod_ready && waitCycles < 50) begin
      tick();
      waitCycles++;
    end
    if (!prod_ready) checkOutput("prod_ready_timeout", 32'd0, 32'd1);
    tick();
    prod_valid = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    len        = '0;
    bias       = '0;
    prod_valid = 1'b0;
    prod_in    = '0;
    out_ready  = 1'b1;
    tick();
    checkOutput("reset_prod_ready", 32'(prod_ready), 32'd0);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_out_data", 32'(out_data), 32'd0);
    checkOutput("reset_out_sat", 32'(out_sat), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    tick();

    // Basic: 0x10 + 2 - 1 + 5 = 0x16
    expQ.push_back({1'b0, 16'h0016});
    applyStimulus(16'h0010, 8'd3);
    checkOutput("basic_busy", 32'(busy), 32'd1);
    sendProd(16'h0002);
    sendProd(16'hFFFF);
    sendProd(16'h0005);
    checkOutput("basic_latency", 32'(out_valid), 32'd1);
    tick();
    checkOutput("basic_idle", 32'(busy), 32'd0);

    // Stalls on both sides
    out_ready = 1'b0;
    expQ.push_back({1'b0, 16'h0016});
    applyStimulus(16'h0010, 8'd3);
    sendProd(16'h0002);
    tick();
    tick();
    checkOutput("stall_prod_ready", 32'(prod_ready), 32'd1);
    checkOutput("stall_no_valid", 32'(out_valid), 32'd0);
    sendProd(16'hFFFF);
    tick();
    tick();
    sendProd(16'h0005);
    checkOutput("stall_done_valid", 32'(out_valid), 32'd1);
    checkOutput("stall_done_prod_ready", 32'(prod_ready), 32'd0);
    tick();
    tick();
    tick();
    checkOutput("stall_held_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    tick();
    checkOutput("stall_released", 32'(out_valid), 32'd0);

    // Positive and negative saturation
    expQ.push_back({1'b1, 16'h7FFF});
    applyStimulus(16'h7000, 8'd2);
    sendProd(16'h7000);
    sendProd(16'h7000);
    tick();
    expQ.push_back({1'b1, 16'h8000});
    applyStimulus(16'h8000, 8'd1);
    sendProd(16'h8000);
    tick();

    // Zero-length operation returns the bias and consumes nothing
    expQ.push_back({1'b0, 16'hFFF0});
    prod_valid = 1'b1;
    prod_in    = 16'h1234;
    applyStimulus(16'hFFF0, 8'd0);
    checkOutput("len0_valid", 32'(out_valid), 32'd1);
    checkOutput("len0_prod_ready", 32'(prod_ready), 32'd0);
    tick();
    checkOutput("len0_after_prod_ready", 32'(prod_ready), 32'd0);
    checkOutput("len0_after_valid", 32'(out_valid), 32'd0);
    prod_valid = 1'b0;

    // Back-to-back reload, then a start during ACCUM is ignored
    expQ.push_back({1'b0, 16'h0008});
    applyStimulus(16'h0005, 8'd1);
    sendProd(16'h0003);
    expQ.push_back({1'b0, 16'h0007});
    applyStimulus(16'h0000, 8'd1);
    checkOutput("b2b_accum", 32'(prod_ready), 32'd1);
    checkOutput("b2b_busy", 32'(busy), 32'd1);
    applyStimulus(16'h0100, 8'd5);
    sendProd(16'h0007);
    checkOutput("b2b_ignored_start", 32'(out_valid), 32'd1);
    tick();

    // Longest run: 255 products of +1 with no counter wrap
    expQ.push_back({1'b0, 16'h00FF});
    applyStimulus(16'h0000, 8'd255);
    for (int i = 0; i < 255; i++) sendProd(16'h0001);
    checkOutput("len255_valid", 32'(out_valid), 32'd1);
    tick();

    // Asynchronous reset in the middle of an operation
    applyStimulus(16'h0000, 8'd4);
    sendProd(16'h0001);
    sendProd(16'h0001);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_prod_ready", 32'(prod_ready), 32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_data", 32'(out_data), 32'd0);
    checkOutput("rst_out_sat", 32'(out_sat), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    expQ.push_back({1'b0, 16'h0002});
    applyStimulus(16'h0001, 8'd1);
    sendProd(16'h0001);
    checkOutput("post_rst_valid", 32'(out_valid), 32'd1);
    tick();
    tick();

    checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
